// File: rtl/dac_pkg.sv
// Shared types and constants for the dual-channel DAC serialiser.
package dac_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_BITS  = 12;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLow,
        StHigh,
        StGap
    } dac_state_e;

    // DAC input register layout: two don't-care zeros, power-down bits, sample.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [1:0]           pd,
                                                         input logic [DATA_BITS-1:0] data);
        return {2'b00, pd, data};
    endfunction

endpackage

// File: rtl/dac_control_if.sv
// Sample-pair handshake and DAC pin bundle for dac_control.
interface dac_control_if;
    import dac_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_BITS-1:0] in_data1;
    logic [DATA_BITS-1:0] in_data2;
    logic [1:0]           pd_mode;
    logic                 DAC_clk;
    logic                 sync_n;
    logic                 Data1;
    logic                 Data2;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output in_valid, in_data1, in_data2, pd_mode,
        input  in_ready, DAC_clk, sync_n, Data1, Data2, busy, frame_done
    );

    modport slave (
        input  in_valid, in_data1, in_data2, pd_mode,
        output in_ready, DAC_clk, sync_n, Data1, Data2, busy, frame_done
    );

endinterface

// File: rtl/dac_shift16.sv
// 16-bit parallel-load, MSB-first shift register for one DAC data line.
module dac_shift16
    import dac_pkg::*;
(
    input  logic                  clk_20M,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [FRAME_BITS-1:0] din,
    output logic                  serial_out
);

    logic [FRAME_BITS-1:0] sr_q;

    always_ff @(posedge clk_20M or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= {sr_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign serial_out = sr_q[FRAME_BITS-1];

endmodule

// File: rtl/dac_control.sv
// Dual-channel DAC frame serialiser: shared DAC_clk/sync_n, two MSB-first data lines.
// Optional one-entry holding register enabled by DAC_DOUBLE_BUF_EN.
module dac_control
    import dac_pkg::*;
#(
    parameter int unsigned HALF_PER = 1,
    parameter int unsigned GAP      = 2
) (
    input  logic          clk_20M,
    input  logic          reset,
    dac_control_if.slave  bus
);

    localparam logic [3:0] HalfLd  = 4'(HALF_PER - 1);
    localparam logic [3:0] GapLd   = 4'(GAP - 1);
    localparam logic [3:0] LastBit = 4'(FRAME_BITS - 1);

    dac_state_e state_q;
    logic [3:0] phase_q;
    logic [3:0] bit_q;
    logic       dac_clk_q, sync_n_q, busy_q, done_q, ready_q;

    logic                  accept, phase_end, to_gap, to_high;
    logic                  start_new, start_hold, sh_load;
    logic [FRAME_BITS-1:0] new1, new2, ld1, ld2;

`ifdef DAC_DOUBLE_BUF_EN
    logic                  hold_full_q, hold_full_d;
    logic [FRAME_BITS-1:0] hold1_q, hold2_q;
`endif

    always_comb begin
        accept    = bus.in_valid && ready_q;
        phase_end = (phase_q == 4'd0);
        new1      = frame_word(bus.pd_mode, bus.in_data1);
        new2      = frame_word(bus.pd_mode, bus.in_data2);
        to_gap    = (state_q == StLow) && phase_end && (bit_q == 4'd0);
        to_high   = (state_q == StLow) && phase_end && (bit_q != 4'd0);
`ifdef DAC_DOUBLE_BUF_EN
        start_new   = accept && (state_q == StIdle);
        start_hold  = hold_full_q && ((state_q == StIdle) || ((state_q == StGap) && phase_end));
        hold_full_d = (accept && !start_new) || (hold_full_q && !start_hold);
`else
        start_new   = accept;
        start_hold  = 1'b0;
`endif
        sh_load = start_new || start_hold || to_gap;
        // Loading zeros on GAP entry parks both data lines low between frames.
        ld1 = '0;
        ld2 = '0;
`ifdef DAC_DOUBLE_BUF_EN
        if (start_hold) begin
            ld1 = hold1_q;
            ld2 = hold2_q;
        end else if (start_new) begin
            ld1 = new1;
            ld2 = new2;
        end
`else
        if (start_new) begin
            ld1 = new1;
            ld2 = new2;
        end
`endif
    end

    always_ff @(posedge clk_20M or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            phase_q   <= 4'd0;
            bit_q     <= 4'd0;
            dac_clk_q <= 1'b1;
            sync_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!phase_end) phase_q <= phase_q - 4'd1;
            unique case (state_q)
                StIdle: begin
                    if (start_new || start_hold) begin
                        state_q  <= StSetup;
                        phase_q  <= HalfLd;
                        bit_q    <= LastBit;
                        sync_n_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                StSetup: begin
                    if (phase_end) begin
                        state_q   <= StLow;
                        phase_q   <= HalfLd;
                        dac_clk_q <= 1'b0;
                    end
                end
                StLow: begin
                    if (phase_end) begin
                        dac_clk_q <= 1'b1;
                        if (bit_q == 4'd0) begin
                            state_q  <= StGap;
                            phase_q  <= GapLd;
                            sync_n_q <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= StHigh;
                            phase_q <= HalfLd;
                            bit_q   <= bit_q - 4'd1;
                        end
                    end
                end
                StHigh: begin
                    if (phase_end) begin
                        state_q   <= StLow;
                        phase_q   <= HalfLd;
                        dac_clk_q <= 1'b0;
                    end
                end
                StGap: begin
                    if (phase_end) begin
                        if (start_hold) begin
                            state_q  <= StSetup;
                            phase_q  <= HalfLd;
                            bit_q    <= LastBit;
                            sync_n_q <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_20M or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
`ifdef DAC_DOUBLE_BUF_EN
            hold_full_q <= 1'b0;
            hold1_q     <= '0;
            hold2_q     <= '0;
`endif
        end else begin
`ifdef DAC_DOUBLE_BUF_EN
            hold_full_q <= hold_full_d;
            ready_q     <= !hold_full_d;
            if (accept && !start_new) begin
                hold1_q <= new1;
                hold2_q <= new2;
            end
`else
            ready_q <= ((state_q == StIdle) && !start_new) || ((state_q == StGap) && phase_end);
`endif
        end
    end

    dac_shift16 u_shift1 (
        .clk_20M    (clk_20M),
        .reset      (reset),
        .load       (sh_load),
        .shift      (to_high),
        .din        (ld1),
        .serial_out (bus.Data1)
    );

    dac_shift16 u_shift2 (
        .clk_20M    (clk_20M),
        .reset      (reset),
        .load       (sh_load),
        .shift      (to_high),
        .din        (ld2),
        .serial_out (bus.Data2)
    );

    assign bus.in_ready   = ready_q;
    assign bus.DAC_clk    = dac_clk_q;
    assign bus.sync_n     = sync_n_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_dac_control.sv
// Randomised bench for dac_control: pin-level serial monitor plus transfer scoreboard.
// Build with DAC_DOUBLE_BUF_EN defined to exercise the holding-register variant.
module tb_dac_control;
    import dac_pkg::*;

    localparam int unsigned H0 = 1;
    localparam int unsigned G0 = 2;
    localparam int unsigned H1 = 3;
    localparam int unsigned G1 = 4;

    logic clk_20M = 1'b0;
    logic rst0, rst1;
    always #25 clk_20M = ~clk_20M;

    dac_control_if bus0 ();
    dac_control_if bus1 ();

    dac_control #(.HALF_PER(H0), .GAP(G0)) u_dut0 (
        .clk_20M (clk_20M),
        .reset   (rst0),
        .bus     (bus0)
    );

    dac_control #(.HALF_PER(H1), .GAP(G1)) u_dut1 (
        .clk_20M (clk_20M),
        .reset   (rst1),
        .bus     (bus1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: each accepted pair becomes {2'b00,pd,data} per channel, queued in order.
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int   m_cyc[2]     = '{default: 0};
    int   m_edges[2]   = '{default: 0};
    int   m_low[2]     = '{default: 0};
    int   m_high[2]    = '{default: 0};
    int   m_badp[2]    = '{default: 0};
    int   m_lastf[2]   = '{default: 0};
    int   m_frames[2]  = '{default: 0};
    int   m_fd[2]      = '{default: 0};
    int   m_idlebad[2] = '{default: 0};
    logic [15:0] m_w1[2];
    logic [15:0] m_w2[2];
    logic m_pclk[2]  = '{default: 1'b1};
    logic m_psync[2] = '{default: 1'b1};
    logic m_armed[2] = '{default: 1'b0};

    task automatic mon(input int i, input logic rst, input logic v, input logic rdy,
                       input logic [11:0] d1, input logic [11:0] d2, input logic [1:0] pd,
                       input logic dclk, input logic sn, input logic q1, input logic q2,
                       input logic fd);
        int unsigned h;
        int unsigned g;
        logic [31:0] e;
        int qs;
        h = (i == 0) ? H0 : H1;
        g = (i == 0) ? G0 : G1;
        if (rst) begin
            if (i == 0) exp_q0.delete(); else exp_q1.delete();
            m_edges[i] = 0; m_low[i] = 0; m_high[i] = 0; m_badp[i] = 0;
            m_pclk[i] = 1'b1; m_psync[i] = 1'b1; m_armed[i] = 1'b0;
            return;
        end
        m_cyc[i]++;
        if (fd) m_fd[i]++;
        if (v && rdy) begin
            e = {2'b00, pd, d1, 2'b00, pd, d2};
            if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        end
        if (!sn) begin
            if (m_psync[i]) begin
                if (m_armed[i]) check_eq("gap_min", 32'(m_high[i] >= int'(g)), 32'd1);
                m_edges[i] = 0; m_badp[i] = 0; m_low[i] = 0;
            end
            m_low[i]++;
            if (m_pclk[i] && !dclk) begin
                if (m_edges[i] > 0 && (m_cyc[i] - m_lastf[i]) != int'(2 * h)) m_badp[i]++;
                m_lastf[i] = m_cyc[i];
                m_edges[i]++;
                m_w1[i] = {m_w1[i][14:0], q1};
                m_w2[i] = {m_w2[i][14:0], q2};
            end
        end else begin
            if (!dclk || q1 || q2) m_idlebad[i]++;
            if (!m_psync[i]) begin
                check_eq("edges", m_edges[i], 16);
                check_eq("sync_len", m_low[i], 32 * h);
                check_eq("clk_period", m_badp[i], 0);
                check_eq("done_pulse", 32'(fd), 32'd1);
                qs = (i == 0) ? exp_q0.size() : exp_q1.size();
                if (qs == 0) begin
                    check_eq("sb_underflow", qs, 1);
                end else begin
                    e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check_eq("words", {m_w1[i], m_w2[i]}, e);
                end
                m_frames[i]++;
                m_high[i] = 0;
                m_armed[i] = 1'b1;
            end
            m_high[i]++;
        end
        m_pclk[i]  = dclk;
        m_psync[i] = sn;
    endtask

    always @(negedge clk_20M) begin
        mon(0, rst0, bus0.in_valid, bus0.in_ready, bus0.in_data1, bus0.in_data2, bus0.pd_mode,
            bus0.DAC_clk, bus0.sync_n, bus0.Data1, bus0.Data2, bus0.frame_done);
        mon(1, rst1, bus1.in_valid, bus1.in_ready, bus1.in_data1, bus1.in_data2, bus1.pd_mode,
            bus1.DAC_clk, bus1.sync_n, bus1.Data1, bus1.Data2, bus1.frame_done);
    end

    task automatic drive(input int i, input logic v, input logic [11:0] d1, input logic [11:0] d2,
                         input logic [1:0] pd);
        if (i == 0) begin
            bus0.in_valid = v; bus0.in_data1 = d1; bus0.in_data2 = d2; bus0.pd_mode = pd;
        end else begin
            bus1.in_valid = v; bus1.in_data1 = d1; bus1.in_data2 = d2; bus1.pd_mode = pd;
        end
    endtask

    // Returns just after the accepting edge; data is then scrambled to prove it was latched.
    task automatic send(input int i, input logic [11:0] d1, input logic [11:0] d2,
                        input logic [1:0] pd);
        int   waited;
        logic rdy;
        waited = 0;
        @(posedge clk_20M); #1;
        drive(i, 1'b1, d1, d2, pd);
        do begin
            @(negedge clk_20M);
            rdy = (i == 0) ? bus0.in_ready : bus1.in_ready;
            waited++;
        end while (!rdy && waited < 300);
        check_eq("send_accept", 32'(rdy), 32'd1);
        @(posedge clk_20M); #1;
        drive(i, 1'b0, ~d1, ~d2, ~pd);
    endtask

    task automatic wait_idle(input int i);
        int   waited;
        logic b;
        waited = 0;
        do begin
            @(negedge clk_20M);
            b = (i == 0) ? bus0.busy : bus1.busy;
            waited++;
        end while (b && waited < 3000);
        check_eq("went_idle", 32'(b), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        int   falls;
        logic prev;

        rst0 = 1'b1;
        rst1 = 1'b1;
        drive(0, 1'b0, 12'h0, 12'h0, PD_NORMAL);
        drive(1, 1'b0, 12'h0, 12'h0, PD_NORMAL);
        repeat (3) @(negedge clk_20M);
        check_eq("reset_outs0", 32'({bus0.in_ready, bus0.DAC_clk, bus0.sync_n, bus0.Data1,
                                     bus0.Data2, bus0.busy, bus0.frame_done}), 32'h30);
        check_eq("reset_outs1", 32'({bus1.in_ready, bus1.DAC_clk, bus1.sync_n, bus1.Data1,
                                     bus1.Data2, bus1.busy, bus1.frame_done}), 32'h30);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk_20M);
        check_eq("ready_after_reset", 32'(bus0.in_ready), 32'd1);

        // Single frame, H=1 G=2.
        send(0, 12'hA5C, 12'h3F1, PD_NORMAL);
`ifndef DAC_DOUBLE_BUF_EN
        cnt = 0;
        do begin
            @(negedge clk_20M);
            cnt++;
        end while (!bus0.in_ready && cnt < 100);
        check_eq("accept_to_ready", cnt, 35);
`endif
        wait_idle(0);

        // Slow instance, full-scale/zero codes with high-Z power-down.
        send(1, 12'hFFF, 12'h000, PD_HIZ);
        wait_idle(1);

        // Reset while bit 7 is on the lines.
        send(0, 12'h5A3, 12'hC3C, PD_1K);
        falls = 0;
        cnt = 0;
        prev = bus0.DAC_clk;
        while (falls < 8 && cnt < 200) begin
            @(negedge clk_20M);
            if (prev && !bus0.DAC_clk) falls++;
            prev = bus0.DAC_clk;
            cnt++;
        end
        check_eq("reached_bit7", falls, 8);
        @(posedge clk_20M); #10;
        rst0 = 1'b1;
        #1;
        check_eq("abort_outs", 32'({bus0.sync_n, bus0.DAC_clk, bus0.frame_done, bus0.busy,
                                    bus0.in_ready, bus0.Data1, bus0.Data2}), 32'h60);
        repeat (2) @(negedge clk_20M);
        rst0 = 1'b0;
        send(0, 12'h123, 12'hFED, PD_100K);
        wait_idle(0);

`ifdef DAC_DOUBLE_BUF_EN
        // Two transfers five cycles apart: the second lands in the holding register.
        send(0, 12'h0F0, 12'h70E, PD_NORMAL);
        repeat (4) @(posedge clk_20M);
        #1;
        drive(0, 1'b1, 12'h9B1, 12'h24D, PD_1K);
        @(negedge clk_20M);
        check_eq("dbuf_ready_second", 32'(bus0.in_ready), 32'd1);
        @(posedge clk_20M); #1;
        drive(0, 1'b0, 12'h000, 12'h000, PD_NORMAL);
        @(negedge clk_20M);
        check_eq("dbuf_ready_full", 32'(bus0.in_ready), 32'd0);
        cnt = 0;
        while (!bus0.sync_n && cnt < 200) begin
            @(negedge clk_20M);
            cnt++;
        end
        cnt = 0;
        while (bus0.sync_n && cnt < 200) begin
            @(negedge clk_20M);
            if (bus0.sync_n) cnt++;
        end
        check_eq("dbuf_gap", cnt, G0);
        wait_idle(0);
`endif

        // Random valid, then sustained valid; data toggles every cycle throughout.
        for (int c = 0; c < 900; c++) begin
            @(posedge clk_20M); #1;
            drive(0, (c >= 450) ? 1'b1 : ($urandom_range(0, 3) == 0),
                  12'($urandom), 12'($urandom), 2'($urandom));
        end
        @(posedge clk_20M); #1;
        drive(0, 1'b0, 12'h0, 12'h0, PD_NORMAL);
        wait_idle(0);

        // A few random frames on the slow instance.
        for (int k = 0; k < 3; k++) begin
            send(1, 12'($urandom), 12'($urandom), 2'($urandom));
            wait_idle(1);
        end

        repeat (5) @(negedge clk_20M);
        check_eq("sb_leftover0", exp_q0.size(), 0);
        check_eq("sb_leftover1", exp_q1.size(), 0);
        check_eq("done_count0", m_fd[0], m_frames[0]);
        check_eq("done_count1", m_fd[1], m_frames[1]);
        check_eq("idle_lines0", m_idlebad[0], 0);
        check_eq("idle_lines1", m_idlebad[1], 0);
        check_eq("frames1", m_frames[1], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dac_control.md
Name: dac_control

Overview:
- Transmit-side counterpart of the dual-channel ADC capture path.
- Accepts two 12-bit parallel samples over a valid/ready handshake.
- Serialises them as simultaneous 16-bit frames on two data lines with a shared serial clock and active-low frame sync. The target is a dual DAC121S101-style output board.
- Sits between the force-processing logic and the DAC pins.

Parameters:
- HALF_PER, 1, serial clock half-period in clk_20M cycles (1..15); DAC_clk = clk_20M / (2*HALF_PER).
- GAP, 2, idle clk_20M cycles with sync_n high between frames (1..15).

Ports:
- clk_20M  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a sample pair.
- in_ready  output  1  block can accept a pair this cycle.
- in_data1  input  12  channel-1 sample.
- in_data2  input  12  channel-2 sample.
- pd_mode  input  2  DAC power-down bits, latched with the data.
- DAC_clk  output  1  serial clock; idles high.
- sync_n  output  1  frame sync, active low.
- Data1  output  1  channel-1 serial data, MSB first.
- Data2  output  1  channel-2 serial data, MSB first.
- busy  output  1  high whenever state is not IDLE.
- frame_done  output  1  one-cycle pulse after the last bit's falling edge.

Behaviour:
- Clock and reset: one clock, clk_20M. Reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE, DAC_clk=1, sync_n=1, Data1=Data2=0, busy=0, frame_done=0, in_ready=0 during reset and 1 in the first cycle after release.
- All outputs are registered.
- Frame word per channel: {2'b00, pd_mode, data[11:0]}, 16 bits, MSB (bit 15) first.
- States: IDLE, SETUP, LOW, HIGH, GAP.
- IDLE:
  - in_ready=1.
  - Transfer occurs when in_valid&&in_ready. Latch both frame words into shift registers and go to SETUP.
- SETUP (H cycles, where H=HALF_PER):
  - sync_n=0, DAC_clk=1, Data1/Data2 = bit 15.
  - Then go to LOW.
- LOW (H cycles):
  - DAC_clk=0. The falling edge on entry is the DAC sample point; data is stable across it.
  - A 4-bit bit counter starts at 15.
  - If count==0, go to GAP.
  - Else go to HIGH and decrement the counter.
- HIGH (H cycles):
  - DAC_clk=1. Data shifts to the next bit on entry, i.e. on the rising edge.
  - Then go to LOW.
- GAP (G cycles, where G=GAP):
  - sync_n=1, DAC_clk=1, Data=0.
  - frame_done=1 in the first GAP cycle only.
  - Then go to IDLE.
- Timing: sync_n is low for exactly 32*H cycles. With H=1, G=2, acceptance to next in_ready is 35 cycles.
- Sixteen falling DAC_clk edges per frame, no more and no fewer.
- A half-phase counter of 4 bits times H; it reloads on every state entry.
- in_valid held while not ready: no effect. Inputs are sampled only on transfer.
- in_data change mid-frame: no effect on the frame in flight.
- Reset mid-frame: outputs return immediately to reset values (sync_n high aborts the DAC frame). No frame_done pulse.
- Back-to-back in_valid: every frame has the full GAP. A new frame never starts without at least G cycles of sync_n high.

Optional Feature:
- Macro DAC_DOUBLE_BUF_EN.
- Defined:
  - Adds a one-entry holding register.
  - in_ready = !hold_full in any state.
  - In IDLE, a transfer goes straight to SETUP as in the base behaviour.
  - While busy, a transfer fills the holding register.
  - At the end of GAP, if hold_full, load from the holding register, clear hold_full, and go directly to SETUP, skipping IDLE. Sustained throughput is one frame per 32H+G cycles.
  - A simultaneous hold-unload and new transfer in the same cycle is impossible, because in_ready=0 while full.
- Undefined: in_ready is high only in IDLE, as in the base behaviour.

Decomposition:
- Shared package dac_pkg:
  - State encoding constants.
  - FRAME_BITS=16, DATA_BITS=12.
  - PD_NORMAL=2'b00, PD_1K=2'b01, PD_100K=2'b10, PD_HIZ=2'b11.
- Sub-module dac_shift16: a 16-bit parallel-load, left-shift register with load and shift enables. Instantiate it once per channel.

Test Plan:
- Single frame: send in_data1=12'hA5C, in_data2=12'h3F1, pd_mode=0. A serial monitor capturing on DAC_clk falling edges while sync_n=0 must see 16'h0A5C and 16'h03F1, with exactly 16 edges, sync_n low for 32 cycles, and one frame_done pulse.
- HALF_PER=3, GAP=4, data 12'hFFF / 12'h000, pd_mode=2'b11: sync_n low for 96 cycles; words captured 16'h3FFF and 16'h3000; DAC_clk period 6 cycles.
- Stall: hold in_valid=1 continuously with distinct values each frame. Every frame must be preceded by at least GAP cycles of sync_n high, and no sample may be dropped or duplicated (check with a scoreboard).
- Reset asserted at bit 7 of a frame: sync_n=1 and DAC_clk=1 within the same cycle, no frame_done; the next transfer produces a complete, correct frame.
- In_data changes mid-frame (toggle every cycle while busy): the captured word equals the value present at the transfer cycle.
- With DAC_DOUBLE_BUF_EN: issue two transfers 5 cycles apart (H=1, G=2). in_ready stays high for the second, then drops. The second frame starts exactly 2 cycles after the first sync_n rises, and both words are correct.
